fp_mul_pipe: RTL and testbench
==============================

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23: stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter MULF, default 6'b011000: opcode that selects multiply.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: operand/opcode presented.
REQ-007 SHALL have port in_ready, output, 1: block can accept this cycle.
REQ-008 SHALL have port opcode_d1, input, 6: operation code.
REQ-009 SHALL have ports floating_num1 and floating_num2, input, W each: IEEE-style operands.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port multiply, output, W: product.
REQ-013 SHALL have port flags, output, 4: {invalid, overflow, underflow, inexact}, aligned with multiply.

Function
REQ-014 SHALL accept an operation when in_valid && in_ready && opcode_d1==MULF; other opcodes are consumed with no result produced.
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/classify, S2 mantissa product (MAN_W+1)x(MAN_W+1), S3 normalize/round/pack; out_valid rises exactly 3 cycles after acceptance when unstalled.
REQ-016 SHALL sustain one accepted operation per cycle; results leave in acceptance order.
REQ-017 SHALL stall the whole pipeline when out_valid && !out_ready; in_ready = !(out_valid && !out_ready); multiply/flags held stable while stalled.
REQ-018 SHALL compute sign = sign1 XOR sign2 for all non-NaN results.
REQ-019 SHALL compute exponent as e1+e2-bias (bias = 2^(EXP_W-1)-1) in signed EXP_W+2 bits; no wrap-around permitted.
REQ-020 SHALL normalize: product in [2,4) shifts right by 1 and increments exponent; product in [1,2) unshifted.
REQ-021 SHALL flush subnormal inputs (exp==0) to signed zero.
REQ-022 SHALL return signed infinity and set overflow+inexact when final biased exponent >= 2^EXP_W-1.
REQ-023 SHALL return signed zero and set underflow+inexact when final biased exponent <= 0 (flush-to-zero).
REQ-024 SHALL return canonical quiet NaN (sign 0, exp all ones, fraction MSB 1, rest 0) if either operand is NaN, or for 0 x inf, the latter also setting invalid.
REQ-025 SHALL return signed infinity for inf x finite nonzero, signed zero for zero x finite, no flags.
REQ-026 SHALL set inexact whenever any discarded product bit is nonzero.
REQ-027 SHALL increment exponent when rounding carries out of the mantissa, re-checking overflow.
REQ-028 SHALL handle simultaneous acceptance and output handoff in the same cycle without loss or duplication.

Reset
REQ-029 SHALL on reset clear all stage valid bits, discarding in-flight operations, including mid-operation.
REQ-030 SHALL drive out_valid=0, multiply=0, flags=0, in_ready=1 while reset is asserted and after release until first acceptance.

Configuration
REQ-031 SHALL honour macro FPMUL_RNE_EN: defined -> round-to-nearest-even using guard and sticky bits; undefined -> truncate toward zero; flags identical either way.

Verification
REQ-032 SHALL verify 0x40400000 x 0x40000000 -> 0x40C00000, flags 0, out_valid exactly 3 cycles after accept.
REQ-033 SHALL verify 0x3FC00000 x 0x3FC00000 -> 0x40100000 (normalize shift); 0x3FC00001 x 0x3FC00001 -> 0x40100002 with FPMUL_RNE_EN, 0x40100001 without, inexact=1.
REQ-034 SHALL verify 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow=1, inexact=1; 0x00800000 x 0x00800000 -> 0x00000000, underflow=1.
REQ-035 SHALL verify 0x00000000 x 0x7F800000 -> 0x7FC00000, invalid=1; 0xBF800000 x 0x7FC00000 -> 0x7FC00000, invalid=0.
REQ-036 SHALL verify back-pressure: 4 back-to-back ops with out_ready=0 -> in_ready drops, first result held stable; out_ready=1 -> all 4 results in order, none lost.
REQ-037 SHALL verify reset asserted with 2 ops in flight -> out_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-style multiplier: unpack/classify, mantissa product, normalize/round/pack.
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_mul_pipe #(
    parameter int          EXP_W = 8,
    parameter int          MAN_W = 23,
    parameter logic [5:0]  MULF  = 6'b011000,
    localparam int         W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [5:0]   opcode_d1,
    input  logic [W-1:0] floating_num1,
    input  logic [W-1:0] floating_num2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] multiply,
    output logic [3:0]   flags
);
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic                 w_stall, w_accept;
    logic                 w_s1, w_s2, w_sign;
    logic [EXP_W-1:0]     w_e1, w_e2;
    logic [MAN_W-1:0]     w_f1, w_f2;
    logic                 w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2;
    logic                 w_spec;
    logic [W-1:0]         w_spec_val;
    logic [3:0]           w_spec_flags;
    logic signed [XW-1:0] w_exp_sum;

    logic                 r_s1_valid, r_s1_sign, r_s1_spec;
    logic signed [XW-1:0] r_s1_exp;
    logic [MW-1:0]        r_s1_m1, r_s1_m2;
    logic [W-1:0]         r_s1_spec_val;
    logic [3:0]           r_s1_spec_flags;

    logic                 r_s2_valid, r_s2_sign, r_s2_spec;
    logic signed [XW-1:0] r_s2_exp;
    logic [PW-1:0]        r_s2_prod;
    logic [W-1:0]         r_s2_spec_val;
    logic [3:0]           r_s2_spec_flags;

    logic                 r_s3_valid;
    logic [W-1:0]         r_mul;
    logic [3:0]           r_flags;

    logic                 w_top, w_guard, w_sticky, w_inexact, w_rnd_up;
    logic [MAN_W-1:0]     w_frac, w_frac_f;
    logic [MAN_W:0]       w_frac_r;
    logic signed [XW-1:0] w_exp_n, w_exp_f;
    logic [W-1:0]         w_res;
    logic [3:0]           w_res_flags;

    assign w_stall   = r_s3_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign w_accept  = in_valid && in_ready && (opcode_d1 == MULF);
    assign out_valid = r_s3_valid;
    assign multiply  = r_mul;
    assign flags     = r_flags;

    assign w_s1    = floating_num1[W-1];
    assign w_s2    = floating_num2[W-1];
    assign w_e1    = floating_num1[W-2 -: EXP_W];
    assign w_e2    = floating_num2[W-2 -: EXP_W];
    assign w_f1    = floating_num1[MAN_W-1:0];
    assign w_f2    = floating_num2[MAN_W-1:0];
    assign w_sign  = w_s1 ^ w_s2;
    assign w_nan1  = (&w_e1) && (|w_f1);
    assign w_nan2  = (&w_e2) && (|w_f2);
    assign w_inf1  = (&w_e1) && !(|w_f1);
    assign w_inf2  = (&w_e2) && !(|w_f2);
    // Subnormals are flushed: a zero exponent field counts as zero regardless of fraction.
    assign w_zero1 = !(|w_e1);
    assign w_zero2 = !(|w_e2);
    assign w_exp_sum = $signed({2'b00, w_e1}) + $signed({2'b00, w_e2}) - BIAS;

    always_comb begin
        w_spec       = 1'b1;
        w_spec_val   = '0;
        w_spec_flags = 4'b0000;
        if (w_nan1 || w_nan2) begin
            w_spec_val = QNAN;
        end else if ((w_inf1 && w_zero2) || (w_zero1 && w_inf2)) begin
            w_spec_val   = QNAN;
            w_spec_flags = 4'b1000;
        end else if (w_inf1 || w_inf2) begin
            w_spec_val = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_zero1 || w_zero2) begin
            w_spec_val = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    // The product of two [1,2) mantissas lies in [1,4); the top bit picks the window.
    assign w_top     = r_s2_prod[PW-1];
    assign w_frac    = w_top ? r_s2_prod[PW-2 -: MAN_W] : r_s2_prod[PW-3 -: MAN_W];
    assign w_guard   = w_top ? r_s2_prod[MAN_W] : r_s2_prod[MAN_W-1];
    assign w_sticky  = w_top ? (|r_s2_prod[MAN_W-1:0]) : (|r_s2_prod[MAN_W-2:0]);
    assign w_inexact = w_guard || w_sticky;
    assign w_exp_n   = r_s2_exp + XW'(w_top);
`ifdef FPMUL_RNE_EN
    assign w_rnd_up  = w_guard && (w_sticky || w_frac[0]);
`else
    assign w_rnd_up  = 1'b0;
`endif
    assign w_frac_r  = {1'b0, w_frac} + (MAN_W+1)'(w_rnd_up);
    assign w_frac_f  = w_frac_r[MAN_W-1:0];
    assign w_exp_f   = w_exp_n + XW'(w_frac_r[MAN_W]);

    always_comb begin
        w_res       = {r_s2_sign, w_exp_f[EXP_W-1:0], w_frac_f};
        w_res_flags = {3'b000, w_inexact};
        if (r_s2_spec) begin
            w_res       = r_s2_spec_val;
            w_res_flags = r_s2_spec_flags;
        end else if (w_exp_f >= EMAX) begin
            w_res       = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_res_flags = 4'b0101;
        end else if (w_exp_f <= EZERO) begin
            w_res       = {r_s2_sign, {(W-1){1'b0}}};
            w_res_flags = 4'b0011;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid      <= 1'b0;
            r_s1_sign       <= 1'b0;
            r_s1_spec       <= 1'b0;
            r_s1_exp        <= '0;
            r_s1_m1         <= '0;
            r_s1_m2         <= '0;
            r_s1_spec_val   <= '0;
            r_s1_spec_flags <= '0;
            r_s2_valid      <= 1'b0;
            r_s2_sign       <= 1'b0;
            r_s2_spec       <= 1'b0;
            r_s2_exp        <= '0;
            r_s2_prod       <= '0;
            r_s2_spec_val   <= '0;
            r_s2_spec_flags <= '0;
            r_s3_valid      <= 1'b0;
            r_mul           <= '0;
            r_flags         <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sign       <= w_sign;
                r_s1_spec       <= w_spec;
                r_s1_exp        <= w_exp_sum;
                r_s1_m1         <= {1'b1, w_f1};
                r_s1_m2         <= {1'b1, w_f2};
                r_s1_spec_val   <= w_spec_val;
                r_s1_spec_flags <= w_spec_flags;
            end
            r_s2_valid      <= r_s1_valid;
            r_s2_sign       <= r_s1_sign;
            r_s2_spec       <= r_s1_spec;
            r_s2_exp        <= r_s1_exp;
            r_s2_prod       <= PW'(r_s1_m1) * PW'(r_s1_m2);
            r_s2_spec_val   <= r_s1_spec_val;
            r_s2_spec_flags <= r_s1_spec_flags;
            r_s3_valid      <= r_s2_valid;
            if (r_s2_valid) begin
                r_mul   <= w_res;
                r_flags <= w_res_flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: vector table through a scoreboard, plus
// latency, back-pressure and mid-flight reset sequences.
module tb_fp_mul_pipe;
    localparam logic [5:0] MULF = 6'b011000;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  opcode_d1;
    logic [31:0] a, b, multiply;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode_d1(opcode_d1), .floating_num1(a), .floating_num2(b),
        .out_valid(out_valid), .out_ready(out_ready), .multiply(multiply), .flags(flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t        vecs[$];
    logic [35:0] sb[$];
    logic [35:0] cur_exp;
    int          checks = 0;
    int          errors = 0;
    int          results_seen = 0;
    bit          done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h_%h required=none", multiply, flags);
                end else begin
                    check("result", 64'({multiply, flags}), 64'(sb.pop_front()));
                    results_seen++;
                end
            end
            if (in_valid && in_ready && opcode_d1 == MULF) sb.push_back(cur_exp);
        end
    end

    task automatic send(input vec_t v);
        int  n;
        bit  acc;
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        opcode_d1 = v.op;
        cur_exp   = {v.res, v.fl};
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stuck required=accept");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic add(input logic [31:0] va, input logic [31:0] vb, input logic [5:0] op,
                       input logic [31:0] res, input logic [3:0] fl);
        vec_t v;
        v.a = va; v.b = vb; v.op = op; v.res = res; v.fl = fl;
        vecs.push_back(v);
    endtask

    initial begin
        int seen0;
        int n;
`ifdef FPMUL_RNE_EN
        add(32'h3FC00001, 32'h3FC00001, MULF, 32'h40100002, 4'b0001);
        add(32'h3FC00000, 32'h3F800001, MULF, 32'h3FC00002, 4'b0001);
`else
        add(32'h3FC00001, 32'h3FC00001, MULF, 32'h40100001, 4'b0001);
        add(32'h3FC00000, 32'h3F800001, MULF, 32'h3FC00001, 4'b0001);
`endif
        add(32'h40400000, 32'h40000000, MULF, 32'h40C00000, 4'b0000);
        add(32'h3FC00000, 32'h3FC00000, MULF, 32'h40100000, 4'b0000);
        add(32'h7F000000, 32'h7F000000, MULF, 32'h7F800000, 4'b0101);
        add(32'hC0000000, 32'h40400000, MULF, 32'hC0C00000, 4'b0000);
        add(32'h00800000, 32'h00800000, MULF, 32'h00000000, 4'b0011);
        add(32'h00000000, 32'h7F800000, MULF, 32'h7FC00000, 4'b1000);
        add(32'hBF800000, 32'h7FC00000, MULF, 32'h7FC00000, 4'b0000);
        add(32'h7F800000, 32'hC0000000, MULF, 32'hFF800000, 4'b0000);
        add(32'h80000000, 32'h40A00000, MULF, 32'h80000000, 4'b0000);
        add(32'h00000001, 32'h40000000, MULF, 32'h00000000, 4'b0000);
        add(32'h807FFFFF, 32'h7F800000, MULF, 32'h7FC00000, 4'b1000);
        add(32'h3FFFFFFF, 32'h3FFFFFFF, MULF, 32'h407FFFFE, 4'b0001);
        add(32'h40400000, 32'h40000000, 6'h00, 32'h0, 4'h0);
        add(32'h3F800000, 32'h3F800000, MULF, 32'h3F800000, 4'b0000);
        add(32'h7F7FFFFF, 32'h3F800000, MULF, 32'h7F7FFFFF, 4'b0000);
        add(32'h7F7FFFFF, 32'h40000000, MULF, 32'h7F800000, 4'b0101);
        add(32'h00800000, 32'h3F800000, MULF, 32'h00800000, 4'b0000);
        add(32'h00800000, 32'h3F000000, MULF, 32'h00000000, 4'b0011);
        add(32'hFF800000, 32'hFF800000, MULF, 32'h7F800000, 4'b0000);
        add(32'h7F800001, 32'h3F800000, MULF, 32'h7FC00000, 4'b0000);
        add(32'h3F800001, 32'h3F800001, MULF, 32'h3F800002, 4'b0001);
        add(32'h3FC00000, 32'h3F800003, MULF, 32'h3FC00004, 4'b0001);
        add(32'h7F000000, 32'h7F000000, 6'h3F, 32'h0, 4'h0);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; opcode_d1 = '0; cur_exp = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_multiply", 64'(multiply), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_multiply", 64'(multiply), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Latency: accept on edge 1, result visible after edge 3.
        in_valid = 1'b1; a = 32'h40400000; b = 32'h40000000; opcode_d1 = MULF;
        cur_exp = {32'h40C00000, 4'b0000};
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_e1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_e2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_e3", 64'(out_valid), 64'd1);
        drain();

        foreach (vecs[i]) send(vecs[i]);
        in_valid = 1'b0;
        drain();

        done = 1'b0;
        fork
            begin
                foreach (vecs[i]) send(vecs[i]);
                in_valid = 1'b0;
                drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Back-pressure: four back-to-back ops with the consumer stalled.
        seen0 = results_seen;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(vecs[i + 2]);
        in_valid = 1'b1; a = vecs[5].a; b = vecs[5].b; opcode_d1 = vecs[5].op;
        cur_exp = {vecs[5].res, vecs[5].fl};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold", 64'({out_valid, multiply, flags}), 64'({1'b1, vecs[2].res, vecs[2].fl}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        check("bp_count", 64'(results_seen - seen0), 64'd4);

        // Reset with two operations in flight, the first parked at the output.
        out_ready = 1'b0;
        send(vecs[3]);
        send(vecs[4]);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_out_valid_before", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'({multiply, flags}), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_stale", 64'(out_valid), 64'd0);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
